clk_display_scan: RTL

//  Consumer of the real-clock time outputs (seconds/minutes/hours, binary).

---
 rtl/clk_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/clk_display_scan.sv | 121 ++++++++++++
 3 files changed

// File: rtl/clk_pkg.sv
// Shared constants and BCD helpers for the real-clock display path.
package clk_pkg;

    localparam logic [5:0] MAX_SEC  = 6'd59;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [4:0] MAX_HOUR = 5'd23;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [3:0] CODE_0     = 4'h0;
    localparam logic [3:0] CODE_1     = 4'h1;
    localparam logic [3:0] CODE_2     = 4'h2;
    localparam logic [3:0] CODE_3     = 4'h3;
    localparam logic [3:0] CODE_4     = 4'h4;
    localparam logic [3:0] CODE_5     = 4'h5;
    localparam logic [3:0] CODE_6     = 4'h6;
    localparam logic [3:0] CODE_7     = 4'h7;
    localparam logic [3:0] CODE_8     = 4'h8;
    localparam logic [3:0] CODE_9     = 4'h9;
    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_DASH  = 4'hF;

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] bcd_units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit code to active-low {g,f,e,d,c,b,a} segment pattern.
module seg7_decode
    import clk_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            CODE_0:    o_seg = 7'b1000000;
            CODE_1:    o_seg = 7'b1111001;
            CODE_2:    o_seg = 7'b0100100;
            CODE_3:    o_seg = 7'b0110000;
            CODE_4:    o_seg = 7'b0011001;
            CODE_5:    o_seg = 7'b0010010;
            CODE_6:    o_seg = 7'b0000010;
            CODE_7:    o_seg = 7'b1111000;
            CODE_8:    o_seg = 7'b0000000;
            CODE_9:    o_seg = 7'b0010000;
            CODE_DASH: o_seg = SEG_DASH;
            default:   o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clk_display_scan.sv
// Scans a per-frame snapshot of HH.MM.SS onto a 6-digit multiplexed
// common-anode 7-segment display with blinking separator and range dashes.
module clk_display_scan
    import clk_pkg::*;
#(
    parameter int unsigned SCAN_DIV      = 100000,
    parameter bit          BLANK_HOUR_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds_in,
    input  logic [5:0] minutes_in,
    input  logic [4:0] hours_in,
    output logic [5:0] digit_an_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic          r_init;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hr;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic       w_tick;
    logic       w_sec_ok;
    logic       w_min_ok;
    logic       w_hr_ok;
    logic [3:0] w_hr_tens;
    logic [3:0] w_code;
    logic [6:0] w_seg;
    logic [5:0] w_an;
    logic       w_dp;

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

    // Snapshot only at frame boundaries so a frame never mixes two times.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
            r_init  <= 1'b1;
            r_sec   <= '0;
            r_min   <= '0;
            r_hr    <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end
            if (r_init || (w_tick && r_idx == 3'd5)) begin
                r_sec <= seconds_in;
                r_min <= minutes_in;
                r_hr  <= hours_in;
            end
            r_init <= 1'b0;
        end
    end

    assign w_sec_ok  = (r_sec <= MAX_SEC);
    assign w_min_ok  = (r_min <= MAX_MIN);
    assign w_hr_ok   = (r_hr <= MAX_HOUR);
    assign w_hr_tens = bcd_tens({1'b0, r_hr});

    always_comb begin
        w_code = CODE_BLANK;
        case (r_idx)
            3'd0: begin
                if (!w_hr_ok) begin
                    w_code = CODE_DASH;
                end else if (BLANK_HOUR_LZ && w_hr_tens == 4'd0) begin
                    w_code = CODE_BLANK;
                end else begin
                    w_code = w_hr_tens;
                end
            end
            3'd1:    w_code = w_hr_ok  ? bcd_units({1'b0, r_hr}) : CODE_DASH;
            3'd2:    w_code = w_min_ok ? bcd_tens(r_min)         : CODE_DASH;
            3'd3:    w_code = w_min_ok ? bcd_units(r_min)        : CODE_DASH;
            3'd4:    w_code = w_sec_ok ? bcd_tens(r_sec)         : CODE_DASH;
            3'd5:    w_code = w_sec_ok ? bcd_units(r_sec)        : CODE_DASH;
            default: w_code = CODE_BLANK;
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    assign w_an = ~(6'b100000 >> r_idx);
    assign w_dp = ~((r_idx == 3'd1 || r_idx == 3'd3) && w_sec_ok && !r_sec[0]);

    // The init cycle stays dark so the first lit digit already uses the snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 6'b111111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (r_init) begin
            r_an  <= 6'b111111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign digit_an_n = r_an;
    assign seg_n      = r_seg;
    assign dp_n       = r_dp;

endmodule
